// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode receiver: frame states,
// scancode prefix bytes and the layout of a queued entry.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] EXT_PREFIX = 8'hE0;
    localparam logic [7:0] BRK_PREFIX = 8'hF0;

    localparam int RD_WIDTH    = 10;
    localparam int RD_EXT_BIT  = 9;
    localparam int RD_BRK_BIT  = 8;
    localparam int RD_CODE_MSB = 7;
    localparam int RD_CODE_LSB = 0;

    function automatic logic [RD_WIDTH-1:0] packEntry(input logic ext, input logic brk,
                                                      input logic [7:0] code);
        logic [RD_WIDTH-1:0] entry;
        entry = '0;
        entry[RD_EXT_BIT] = ext;
        entry[RD_BRK_BIT] = brk;
        entry[RD_CODE_MSB:RD_CODE_LSB] = code;
        return entry;
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead synchronous FIFO; a push at full is accepted only when a pop
// happens in the same cycle.
module ps2_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_valid,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_empty;
    logic             w_doPush;
    logic             w_doPop;

    assign w_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign w_doPop  = i_pop & ~w_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the read port is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rdPtr];
    assign o_valid = ~w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/ps2_scan_controller.sv
// PS/2 keyboard receiver: synchronizes the bus, deframes 11-bit frames,
// folds E0/F0 prefixes into flags and queues the resulting scancodes.
module ps2_scan_controller
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            PS2_CLK,
    input  logic                            PS2_DAT,
    input  logic                            rd_en,
    output logic [RD_WIDTH-1:0]             rd_data,
    output logic                            rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    input  logic                            err_clear,
    output logic                            overflow,
    output logic                            parity_err,
    output logic                            framing_err
);

    localparam int         TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      r_clkSync;
    logic [1:0]      r_datSync;
    logic            r_clkPrev;
    ps2_state_t      r_state;
    ps2_state_t      w_nextState;
    logic [2:0]      r_bitIdx;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [TO_W-1:0] r_timeout;
    logic            r_extPending;
    logic            r_brkPending;
    logic            r_overflow;
    logic            r_parityErr;
    logic            r_framingErr;

    logic w_fall;
    logic w_dat;
    logic w_shiftEn;
    logic w_parEn;
    logic w_frameDone;
    logic w_timeoutHit;
    logic w_parOk;
    logic w_good;
    logic w_isExt;
    logic w_isBrk;
    logic w_push;
    logic w_pop;
    logic w_full;

    // Synchronizers idle at 1 so reset release never fakes a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clkSync <= 2'b11;
            r_datSync <= 2'b11;
            r_clkPrev <= 1'b1;
        end else begin
            r_clkSync <= {r_clkSync[0], PS2_CLK};
            r_datSync <= {r_datSync[0], PS2_DAT};
            r_clkPrev <= r_clkSync[1];
        end
    end

    assign w_fall = r_clkPrev & ~r_clkSync[1];
    assign w_dat  = r_datSync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState  = r_state;
        w_shiftEn    = 1'b0;
        w_parEn      = 1'b0;
        w_frameDone  = 1'b0;
        w_timeoutHit = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_fall && !w_dat) w_nextState = ST_DATA;
            ST_DATA:   if (w_fall) begin
                           w_shiftEn = 1'b1;
                           if (r_bitIdx == 3'd7) w_nextState = ST_PARITY;
                       end
            ST_PARITY: if (w_fall) begin
                           w_parEn     = 1'b1;
                           w_nextState = ST_STOP;
                       end
            ST_STOP:   if (w_fall) begin
                           w_frameDone = 1'b1;
                           w_nextState = ST_IDLE;
                       end
            default:   w_nextState = ST_IDLE;
        endcase
        // A stalled frame is abandoned; a real edge in the same cycle takes precedence.
        if (r_state != ST_IDLE && !w_fall && r_timeout == TO_MAX) begin
            w_nextState  = ST_IDLE;
            w_timeoutHit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_timeout <= '0;
        end else begin
            if (r_state == ST_IDLE) r_bitIdx <= '0;
            else if (w_shiftEn)     r_bitIdx <= r_bitIdx + 1'b1;
            if (w_shiftEn) r_shift  <= {w_dat, r_shift[7:1]};
            if (w_parEn)   r_parity <= w_dat;
            if (w_fall || r_state == ST_IDLE) r_timeout <= '0;
            else if (r_timeout != TO_MAX)     r_timeout <= r_timeout + 1'b1;
        end
    end

    assign w_parOk = ^{r_shift, r_parity};
    assign w_good  = w_frameDone & w_dat & w_parOk;
    assign w_isExt = w_good & (r_shift == EXT_PREFIX);
    assign w_isBrk = w_good & (r_shift == BRK_PREFIX);
    assign w_push  = w_good & ~w_isExt & ~w_isBrk;
    assign w_pop   = rd_en & rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_extPending <= 1'b0;
            r_brkPending <= 1'b0;
        end else if (w_push) begin
            r_extPending <= 1'b0;
            r_brkPending <= 1'b0;
        end else begin
            if (w_isExt) r_extPending <= 1'b1;
            if (w_isBrk) r_brkPending <= 1'b1;
        end
    end

    // Sticky flags: a fresh error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_parityErr  <= 1'b0;
            r_framingErr <= 1'b0;
        end else begin
            r_overflow   <= (w_push & w_full & ~w_pop) | (r_overflow & ~err_clear);
            r_parityErr  <= (w_frameDone & ~w_parOk) | (r_parityErr & ~err_clear);
            r_framingErr <= (w_frameDone & ~w_dat) | w_timeoutHit | (r_framingErr & ~err_clear);
        end
    end

    ps2_sync_fifo #(
        .WIDTH (RD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (packEntry(r_extPending, r_brkPending, r_shift)),
        .i_pop   (rd_en),
        .o_rdata (rd_data),
        .o_valid (rd_valid),
        .o_full  (w_full),
        .o_count (fifo_count)
    );

    assign overflow    = r_overflow;
    assign parity_err  = r_parityErr;
    assign framing_err = r_framingErr;

endmodule
